// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: sequential PC generation, synchronous-read memory
// interface, one-entry skid buffer toward decode, redirect and misalignment handling.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ADDR_W   = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              mem_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [31:0]       mem_rdata_i,
  input  logic              redirect_i,
  input  logic [31:0]       redirect_pc_i,
  input  logic              id_ready_i,
  output logic              instr_valid_o,
  output logic [31:0]       instr_o,
  output logic [31:0]       instr_pc_o,
  output logic              misaligned_o
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_HOLD, S_HALT} state_e;

  state_e      state_q, state_d;
  logic [31:0] next_pc_q, next_pc_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_pc_q, rsp_pc_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic        mis_q, mis_d;

  logic        issue;
  logic [31:0] fetch_pc;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_BOOT;
      next_pc_q    <= RESET_PC;
      rsp_valid_q  <= 1'b0;
      rsp_pc_q     <= '0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      mis_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      next_pc_q    <= next_pc_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_pc_q     <= rsp_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      mis_q        <= mis_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    next_pc_d    = next_pc_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_pc_d     = rsp_pc_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    mis_d        = 1'b0;
    issue        = 1'b0;
    fetch_pc     = redirect_i ? redirect_pc_i : next_pc_q;

    // The skid always wins over the live memory response.
    out_valid = 1'b0;
    out_instr = NOP;
    out_pc    = '0;
    if (skid_valid_q) begin
      out_valid = 1'b1;
      out_instr = skid_instr_q;
      out_pc    = skid_pc_q;
    end else if (rsp_valid_q) begin
      out_valid = 1'b1;
      out_instr = mem_rdata_i;
      out_pc    = rsp_pc_q;
    end

    if (redirect_i) begin
      rsp_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
      if (redirect_pc_i[1:0] == 2'b00) begin
        issue   = 1'b1;
        state_d = S_RUN;
      end else begin
        mis_d   = 1'b1;
        state_d = S_HALT;
      end
    end else begin
      unique case (state_q)
        S_BOOT: state_d = S_RUN;
        S_RUN: begin
          // The response cannot be replayed from memory, so park it in the skid.
          if (rsp_valid_q && !id_ready_i) begin
            skid_valid_d = 1'b1;
            skid_instr_d = mem_rdata_i;
            skid_pc_d    = rsp_pc_q;
            rsp_valid_d  = 1'b0;
            state_d      = S_HOLD;
          end else begin
            issue = 1'b1;
          end
        end
        S_HOLD: begin
          if (id_ready_i) begin
            skid_valid_d = 1'b0;
            issue        = 1'b1;
            state_d      = S_RUN;
          end
        end
        S_HALT: ;
        default: state_d = S_BOOT;
      endcase
    end

    if (issue) begin
      rsp_valid_d = 1'b1;
      rsp_pc_d    = fetch_pc;
      next_pc_d   = fetch_pc + 32'd4;
    end

    mem_en_o      = issue && !rst_i;
    mem_addr_o    = mem_en_o ? fetch_pc[ADDR_W+1:2] : '0;
    instr_valid_o = out_valid && !redirect_i && !rst_i;
    instr_o       = instr_valid_o ? out_instr : NOP;
    instr_pc_o    = instr_valid_o ? out_pc : '0;
    misaligned_o  = mis_q && !rst_i;
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios with literal expectations plus a
// transaction-level model of the fetch and delivery streams checked every cycle.
module tb_fetch_ctrl;

  localparam int unsigned AW  = 10;
  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          mem_en_o;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   mem_rdata_i = '0;
  logic          redirect_i;
  logic [31:0]   redirect_pc_i;
  logic          id_ready_i;
  logic          instr_valid_o;
  logic [31:0]   instr_o;
  logic [31:0]   instr_pc_o;
  logic          misaligned_o;

  always #5 clk_i = ~clk_i;

  fetch_ctrl #(.RESET_PC(RPC), .ADDR_W(AW)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .mem_en_o      (mem_en_o),
    .mem_addr_o    (mem_addr_o),
    .mem_rdata_i   (mem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .id_ready_i    (id_ready_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .misaligned_o  (misaligned_o)
  );

  function automatic logic [31:0] mem_word(input logic [AW-1:0] w);
    return 32'hA500_0000 | 32'(w);
  endfunction

  // Synchronous-read memory; data is garbage unless a read was issued.
  always @(posedge clk_i) mem_rdata_i <= mem_en_o ? mem_word(mem_addr_o) : 32'hDEAD_BEEF;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Model state: next PC decode must accept, next PC the fetcher must issue.
  logic [31:0] exp_pc = RPC, nxt_fetch = RPC;
  bit          halted = 1'b0;
  bit          p_rst = 1'b1, p_mis = 1'b0, p_hold = 1'b0, p_issue = 1'b0;
  logic [31:0] p_instr = '0, p_pc = '0, p_fetch = '0;

  always @(negedge clk_i) begin
    logic [31:0] fa;
    fa = redirect_i ? redirect_pc_i : nxt_fetch;
    if (rst_i || (p_rst && !redirect_i)) begin
      check("idle_en", 32'(mem_en_o), 32'd0);
      check("idle_addr", 32'(mem_addr_o), 32'd0);
      check("idle_valid", 32'(instr_valid_o), 32'd0);
      check("idle_instr", instr_o, NOP);
      check("idle_pc", instr_pc_o, 32'd0);
    end
    check("misaligned", 32'(misaligned_o), 32'(p_mis && !rst_i));
    if (!rst_i) begin
      if (instr_valid_o) check("instr_data", instr_o, mem_word(instr_pc_o[AW+1:2]));
      else begin
        check("nop_instr", instr_o, NOP);
        check("nop_pc", instr_pc_o, 32'd0);
      end
      if (redirect_i) begin
        check("redir_valid", 32'(instr_valid_o), 32'd0);
        check("redir_issue", 32'(mem_en_o), 32'(redirect_pc_i[1:0] == 2'b00));
      end else if (halted) begin
        check("halt_en", 32'(mem_en_o), 32'd0);
        check("halt_valid", 32'(instr_valid_o), 32'd0);
      end
      if (p_hold && !redirect_i) begin
        check("stall_valid", 32'(instr_valid_o), 32'd1);
        check("stall_instr", instr_o, p_instr);
        check("stall_pc", instr_pc_o, p_pc);
      end
      if (p_issue && !redirect_i) begin
        check("lat_valid", 32'(instr_valid_o), 32'd1);
        check("lat_pc", instr_pc_o, p_fetch);
      end
      if (mem_en_o) begin
        check("fetch_addr", 32'(mem_addr_o), 32'(fa[AW+1:2]));
        nxt_fetch = fa + 32'd4;
      end
      if (instr_valid_o && id_ready_i && !redirect_i) begin
        check("accept_pc", instr_pc_o, exp_pc);
        exp_pc = exp_pc + 32'd4;
      end
      if (redirect_i) begin
        if (redirect_pc_i[1:0] == 2'b00) begin
          exp_pc = redirect_pc_i;
          halted = 1'b0;
        end else begin
          halted = 1'b1;
        end
      end
    end else begin
      exp_pc    = RPC;
      nxt_fetch = RPC;
      halted    = 1'b0;
    end
    p_rst   = rst_i;
    p_mis   = redirect_i && (redirect_pc_i[1:0] != 2'b00) && !rst_i;
    p_hold  = !rst_i && instr_valid_o && !id_ready_i && !redirect_i;
    p_instr = instr_o;
    p_pc    = instr_pc_o;
    p_issue = mem_en_o && !rst_i;
    p_fetch = fa;
  end

  // Apply inputs just after a rising edge, then wait to the falling edge.
  task automatic cyc(input bit r, input bit rd, input bit red, input logic [31:0] pc);
    @(posedge clk_i);
    #1;
    rst_i         = r;
    id_ready_i    = rd;
    redirect_i    = red;
    redirect_pc_i = pc;
    @(negedge clk_i);
  endtask

  initial begin
    rst_i = 1'b1; id_ready_i = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0;
    @(negedge clk_i);
    check("rst_valid", 32'(instr_valid_o), 32'd0);
    check("rst_en", 32'(mem_en_o), 32'd0);
    cyc(0, 1, 0, 0);                                   // BOOT
    check("boot_en", 32'(mem_en_o), 32'd0);
    cyc(0, 1, 0, 0);
    check("c2_en", 32'(mem_en_o), 32'd1);
    check("c2_addr", 32'(mem_addr_o), 32'd0);
    cyc(0, 1, 0, 0);
    check("c3_addr", 32'(mem_addr_o), 32'd1);
    check("c3_pc", instr_pc_o, 32'h0);
    check("c3_instr", instr_o, 32'hA500_0000);
    cyc(0, 1, 0, 0);
    check("c4_addr", 32'(mem_addr_o), 32'd2);
    check("c4_pc", instr_pc_o, 32'h4);
    cyc(0, 0, 0, 0);                                   // decode stalls on 0x8
    check("c5_pc", instr_pc_o, 32'h8);
    check("c5_en", 32'(mem_en_o), 32'd0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    check("c7_pc", instr_pc_o, 32'h8);
    check("c7_instr", instr_o, 32'hA500_0002);
    check("c7_en", 32'(mem_en_o), 32'd0);
    cyc(0, 1, 0, 0);
    check("c8_pc", instr_pc_o, 32'h8);
    check("c8_addr", 32'(mem_addr_o), 32'd3);
    cyc(0, 1, 0, 0);
    check("c9_pc", instr_pc_o, 32'hC);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 32'h100);                             // redirect with skid full
    check("c11_valid", 32'(instr_valid_o), 32'd0);
    check("c11_addr", 32'(mem_addr_o), 32'h40);
    cyc(0, 1, 0, 0);
    check("c12_pc", instr_pc_o, 32'h100);
    cyc(0, 1, 1, 32'h102);
    check("c13_en", 32'(mem_en_o), 32'd0);
    cyc(0, 1, 0, 0);
    check("c14_mis", 32'(misaligned_o), 32'd1);
    cyc(0, 1, 0, 0);
    check("c15_mis", 32'(misaligned_o), 32'd0);
    check("c15_en", 32'(mem_en_o), 32'd0);
    cyc(0, 1, 1, 32'h103);
    cyc(0, 1, 0, 0);
    check("c17_mis", 32'(misaligned_o), 32'd1);
    cyc(0, 1, 1, 32'h200);
    check("c18_addr", 32'(mem_addr_o), 32'h80);
    cyc(0, 1, 0, 0);
    check("c19_pc", instr_pc_o, 32'h200);
    cyc(0, 1, 1, 32'hFFFF_FFFC);
    check("c20_addr", 32'(mem_addr_o), 32'h3FF);
    cyc(0, 1, 0, 0);
    check("c21_pc", instr_pc_o, 32'hFFFF_FFFC);
    check("c21_addr", 32'(mem_addr_o), 32'd0);
    cyc(0, 1, 0, 0);
    check("c22_pc", instr_pc_o, 32'h0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);                                   // HOLD
    check("c24_pc", instr_pc_o, 32'h4);
    cyc(1, 1, 0, 0);                                   // reset during HOLD
    check("c25_valid", 32'(instr_valid_o), 32'd0);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    check("c27_addr", 32'(mem_addr_o), 32'(RPC[AW+1:2]));
    check("c27_en", 32'(mem_en_o), 32'd1);
    cyc(1, 1, 0, 0);
    cyc(0, 1, 1, 32'h40);                              // redirect during BOOT
    check("c30_en", 32'(mem_en_o), 32'd1);
    check("c30_addr", 32'(mem_addr_o), 32'h10);
    cyc(0, 1, 0, 0);
    check("c31_pc", instr_pc_o, 32'h40);
    cyc(0, 1, 1, 32'h300);                             // redirect beats acceptance
    check("c32_valid", 32'(instr_valid_o), 32'd0);
    cyc(0, 1, 0, 0);
    check("c33_pc", instr_pc_o, 32'h300);
    for (int i = 0; i < 400; i++) begin
      int unsigned r;
      r = $urandom_range(0, 63);
      if (r == 0)       cyc(1, 1'($urandom_range(0, 1)), 0, 0);
      else if (r < 5)   cyc(0, 1'($urandom_range(0, 1)), 1, {20'h0, 10'($urandom), 2'b00});
      else if (r == 5)  cyc(0, 1, 1, {20'h0, 10'($urandom), 2'b10});
      else              cyc(0, $urandom_range(0, 3) != 0, 0, 0);
    end
    cyc(0, 1, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
